imr_adc_7476a_sampler: RTL and testbench
========================================

// Module: imr_adc_7476a_sampler
// PURPOSE
//  Periodic sampling sequencer for imr_adc_7476a_core. Drives the core's Ctrl/IRQ registers to fire one
//  single-conversion per sample-period tick, handshakes the ready IRQ, packs A/B results into a FIFO and
//  streams them out. Sits between the AXI config regs and the core; the core is no longer CPU-paced.
// PARAMETERS
//  FIFO_DEPTH    16    sample FIFO entries, power of 2, >=2
//  PERIOD_W      24    width of sample-period counter (SysClk cycles)
//  TIMEOUT_CLKS  4096  SysClk cycles allowed from START to core ready before abort
// PORTS
//  SysClk               in   1       system clock, 100 MHz
//  RST_n                in   1       async active-low reset
//  Cfg_Enable           in   1       sequencer enable; mapped to core CTRL_EN
//  Cfg_Start            in   1       1-cycle pulse: begin run
//  Cfg_Stop             in   1       1-cycle pulse: end run after current conversion
//  Cfg_ClkDiv           in   CDW     core SCLK divider N; CDW = CTRL_CLKDIV_MSB-CTRL_CLKDIV_LSB+1
//  Cfg_Period           in   PERIOD_W SysClk cycles between conversion starts (0 treated as 1)
//  Cfg_Count            in   16      samples per run; 0 = free-run until stop
//  Ctrl_Register        out  32      to core: EN, START, CONT=0, CLKDIV fields only, rest 0
//  IRQ_Register         out  32      to core: IRQ_EN=1 while running, IRQ_CLR pulse
//  Status_Register      in   32      from core (BUSY, RDY bits used)
//  ADC_Data_A_Register  in   32      from core, bits [11:0] used
//  ADC_Data_B_Register  in   32      from core, bits [11:0] used
//  IP_IRQ               in   1       from core, data-ready
//  Sample_Data          out  SDW     FIFO head {B[11:0],A[11:0]}; SDW=24 (40 with timestamp)
//  Sample_Valid         out  1       FIFO non-empty
//  Sample_Ready         in   1       consumer pop; pop when Valid & Ready
//  Fifo_Level           out  $clog2(FIFO_DEPTH)+1  current occupancy
//  Seq_Busy             out  1       run in progress
//  Seq_Overflow         out  1       sticky: sample dropped, FIFO full
//  Seq_Overrun          out  1       sticky: period tick while conversion still pending
//  Seq_Timeout          out  1       sticky: core ready not seen within TIMEOUT_CLKS
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, counters 0. Core shares RST_n.
//  FSM: IDLE -> WAIT_TICK -> ARM -> WAIT_RDY -> CLEAR -> WAIT_IDLE -> WAIT_TICK | IDLE.
//   IDLE: Cfg_Start & Cfg_Enable -> clear sticky flags and sample count, load period counter so first
//     tick is next cycle, Seq_Busy=1, go WAIT_TICK. Cfg_Start without Cfg_Enable ignored.
//   WAIT_TICK: on tick -> ARM. Stop pending, Cfg_Enable low, or count reached -> IDLE.
//   ARM: START=1 (core sees rising edge; START previously 0 by construction), timeout counter cleared.
//   WAIT_RDY: START held; IP_IRQ=1 -> push {B,A} to FIFO, go CLEAR. Timeout -> Seq_Timeout=1, START=0, IDLE.
//   CLEAR: IRQ_CLR=1 for exactly one cycle; START still held (core needs START at end of its quiet time).
//   WAIT_IDLE: START held until Status BUSY=0, then START=0 next cycle, sample count +1, -> WAIT_TICK.
//  Period counter: free-running down-counter while Seq_Busy; tick at 0, reload Cfg_Period-1.
//   Tick outside WAIT_TICK -> Seq_Overrun=1, tick discarded (no queueing).
//  Cfg_Stop / Cfg_Enable low mid-conversion: no abort; conversion completes and is pushed, then IDLE.
//  Count: stop after Cfg_Count pushes attempted (dropped samples count). 16-bit, no wrap in free-run.
//  FIFO: push when full -> word dropped, Seq_Overflow=1; full check uses pre-pop occupancy (simultaneous
//   pop on full still drops). Pop on empty ignored. Push+pop same cycle on non-full: level unchanged.
//  Sample_Data valid combinationally from FIFO head; first push visible 1 cycle after CLEAR entry.
//  Config inputs sampled live; Cfg_ClkDiv/Cfg_Period changes take effect at next ARM / reload.
//  Status_Register BUSY/RDY decoded via STATUS_BUSY_BIT / STATUS_RDY_BIT defines.
// CONFIGURATION
//  IMR_ADC_SAMPLER_TIMESTAMP_EN defined: 16-bit free-running SysClk/16 counter (reset 0, wraps) captured at
//   ARM; FIFO word = {ts[15:0],B[11:0],A[11:0]}, SDW=40.
//  Undefined: no timestamp logic, SDW=24, word = {B,A}.
// TESTING
//  Cfg_ClkDiv=5, Period=2000, Count=4, ADC model A=0x123,B=0xABC -> 4 words 0xABC123, Busy falls, flags 0.
//  Period=10 (shorter than one conversion) -> Seq_Overrun=1, samples still delivered, no core lockup.
//  Sample_Ready=0, Count=20, FIFO_DEPTH=16 -> Fifo_Level=16, Seq_Overflow=1, 16 words then popped intact.
//  ADC model never returns IRQ -> Seq_Timeout=1 after 4096 cycles, START=0, FSM IDLE, Busy=0.
//  Count=0, Cfg_Stop mid-SHIFT -> in-flight sample pushed, then IDLE; RST_n low mid-run -> all outputs 0.
//  TIMESTAMP_EN build, Period=1600 -> consecutive ts fields differ by 100 (mod 2^16).

Source files
------------

// File: rtl/imr_adc_7476a_sampler.sv
// Periodic single-conversion sequencer for imr_adc_7476a_core with a sample FIFO; timestamp via IMR_ADC_SAMPLER_TIMESTAMP_EN.
// Latency: a sample is visible on Sample_Data one cycle after CLEAR is entered.
// Backpressure: Sample_Valid/Sample_Ready pop; a push into a full FIFO is dropped and sets Seq_Overflow.

`ifndef CTRL_EN_BIT
`define CTRL_EN_BIT 0
`endif
`ifndef CTRL_START_BIT
`define CTRL_START_BIT 1
`endif
`ifndef CTRL_CONT_BIT
`define CTRL_CONT_BIT 2
`endif
`ifndef CTRL_CLKDIV_LSB
`define CTRL_CLKDIV_LSB 8
`endif
`ifndef CTRL_CLKDIV_MSB
`define CTRL_CLKDIV_MSB 15
`endif
`ifndef IRQ_EN_BIT
`define IRQ_EN_BIT 0
`endif
`ifndef IRQ_CLR_BIT
`define IRQ_CLR_BIT 1
`endif
`ifndef STATUS_BUSY_BIT
`define STATUS_BUSY_BIT 0
`endif
`ifndef STATUS_RDY_BIT
`define STATUS_RDY_BIT 1
`endif
`ifndef IMR_ADC_SAMPLER_SDW
`ifdef IMR_ADC_SAMPLER_TIMESTAMP_EN
`define IMR_ADC_SAMPLER_SDW 40
`else
`define IMR_ADC_SAMPLER_SDW 24
`endif
`endif

module imr_adc_7476a_sampler #(
   parameter int FIFO_DEPTH   = 16,
   parameter int PERIOD_W     = 24,
   parameter int TIMEOUT_CLKS = 4096
) (
   input  logic                                       SysClk,
   input  logic                                       RST_n,
   input  logic                                       Cfg_Enable,
   input  logic                                       Cfg_Start,
   input  logic                                       Cfg_Stop,
   input  logic [`CTRL_CLKDIV_MSB-`CTRL_CLKDIV_LSB:0] Cfg_ClkDiv,
   input  logic [PERIOD_W-1:0]                        Cfg_Period,
   input  logic [15:0]                                Cfg_Count,
   output logic [31:0]                                Ctrl_Register,
   output logic [31:0]                                IRQ_Register,
   input  logic [31:0]                                Status_Register,
   input  logic [31:0]                                ADC_Data_A_Register,
   input  logic [31:0]                                ADC_Data_B_Register,
   input  logic                                       IP_IRQ,
   output logic [`IMR_ADC_SAMPLER_SDW-1:0]            Sample_Data,
   output logic                                       Sample_Valid,
   input  logic                                       Sample_Ready,
   output logic [$clog2(FIFO_DEPTH):0]                Fifo_Level,
   output logic                                       Seq_Busy,
   output logic                                       Seq_Overflow,
   output logic                                       Seq_Overrun,
   output logic                                       Seq_Timeout
);
   localparam int CDW = `CTRL_CLKDIV_MSB - `CTRL_CLKDIV_LSB + 1;
   localparam int SDW = `IMR_ADC_SAMPLER_SDW;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;
   localparam int TW  = $clog2(TIMEOUT_CLKS) + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_TICK, S_ARM, S_WAIT_RDY, S_CLEAR, S_WAIT_IDLE
   } state_t;

   state_t              state, state_nxt;
   logic [PERIOD_W-1:0] per_cnt;
   logic [TW-1:0]       to_cnt;
   logic [15:0]         samp_cnt;
   logic                stop_pend;
   logic                ctrl_en;
   logic [CDW-1:0]      clkdiv_q;
   logic [SDW-1:0]      conv_word, conv_hold;
   logic [SDW-1:0]      fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [LW-1:0]       level;

   logic run_go, tick, core_busy, count_hit, end_run, to_hit, start_on;
   logic push, fifo_full, do_push, do_pop;
   logic unused_in;

   assign core_busy = Status_Register[`STATUS_BUSY_BIT];
   assign unused_in = ^{Status_Register, ADC_Data_A_Register[31:12], ADC_Data_B_Register[31:12]};

   assign Seq_Busy  = (state != S_IDLE);
   assign run_go    = (state == S_IDLE) && Cfg_Start && Cfg_Enable;
   assign tick      = Seq_Busy && (per_cnt == '0);
   assign count_hit = (Cfg_Count != 16'd0) && (samp_cnt >= Cfg_Count);
   assign end_run   = stop_pend || Cfg_Stop || !Cfg_Enable || count_hit;
   assign to_hit    = (to_cnt == TW'(TIMEOUT_CLKS - 1));
   assign start_on  = (state == S_ARM) || (state == S_WAIT_RDY) ||
                      (state == S_CLEAR) || (state == S_WAIT_IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (run_go) state_nxt = S_WAIT_TICK;
         S_WAIT_TICK: begin
            if (end_run)   state_nxt = S_IDLE;
            else if (tick) state_nxt = S_ARM;
         end
         S_ARM:       state_nxt = S_WAIT_RDY;
         S_WAIT_RDY: begin
            if (IP_IRQ)      state_nxt = S_CLEAR;
            else if (to_hit) state_nxt = S_IDLE;
         end
         S_CLEAR:     state_nxt = S_WAIT_IDLE;
         S_WAIT_IDLE: if (!core_busy) state_nxt = S_WAIT_TICK;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge SysClk or negedge RST_n) begin
      if (!RST_n) begin
         state        <= S_IDLE;
         per_cnt      <= '0;
         to_cnt       <= '0;
         samp_cnt     <= '0;
         stop_pend    <= 1'b0;
         ctrl_en      <= 1'b0;
         clkdiv_q     <= '0;
         conv_hold    <= '0;
         Seq_Overrun  <= 1'b0;
         Seq_Timeout  <= 1'b0;
      end else begin
         state   <= state_nxt;
         ctrl_en <= Cfg_Enable;

         // First tick lands on the cycle after start; afterwards the counter never pauses mid-run.
         if (run_go)
            per_cnt <= '0;
         else if (Seq_Busy)
            per_cnt <= (per_cnt != '0) ? per_cnt - PERIOD_W'(1) :
                       (Cfg_Period == '0) ? '0 : Cfg_Period - PERIOD_W'(1);

         if (run_go)
            stop_pend <= 1'b0;
         else if (Cfg_Stop && Seq_Busy)
            stop_pend <= 1'b1;

         if (state == S_ARM)
            to_cnt <= '0;
         else if (state == S_WAIT_RDY && !to_hit)
            to_cnt <= to_cnt + TW'(1);

         if (run_go)
            samp_cnt <= '0;
         else if (state == S_WAIT_IDLE && !core_busy && samp_cnt != 16'hFFFF)
            samp_cnt <= samp_cnt + 16'd1;

         if (state == S_WAIT_TICK && state_nxt == S_ARM)
            clkdiv_q <= Cfg_ClkDiv;

         if (state == S_WAIT_RDY && IP_IRQ)
            conv_hold <= conv_word;

         if (run_go)
            Seq_Overrun <= 1'b0;
         else if (tick && state != S_WAIT_TICK)
            Seq_Overrun <= 1'b1;

         if (run_go)
            Seq_Timeout <= 1'b0;
         else if (state == S_WAIT_RDY && !IP_IRQ && to_hit)
            Seq_Timeout <= 1'b1;
      end
   end

`ifdef IMR_ADC_SAMPLER_TIMESTAMP_EN
   logic [3:0]  ts_div;
   logic [15:0] ts_cnt, ts_cap;

   always_ff @(posedge SysClk or negedge RST_n) begin
      if (!RST_n) begin
         ts_div <= '0;
         ts_cnt <= '0;
         ts_cap <= '0;
      end else begin
         ts_div <= ts_div + 4'd1;
         if (ts_div == 4'hF)
            ts_cnt <= ts_cnt + 16'd1;
         if (state == S_ARM)
            ts_cap <= ts_cnt;
      end
   end

   assign conv_word = {ts_cap, ADC_Data_B_Register[11:0], ADC_Data_A_Register[11:0]};
`else
   assign conv_word = {ADC_Data_B_Register[11:0], ADC_Data_A_Register[11:0]};
`endif

   always_comb begin
      Ctrl_Register = '0;
      Ctrl_Register[`CTRL_EN_BIT]    = ctrl_en;
      Ctrl_Register[`CTRL_START_BIT] = start_on;
      Ctrl_Register[`CTRL_CLKDIV_MSB:`CTRL_CLKDIV_LSB] = clkdiv_q;
      IRQ_Register = '0;
      IRQ_Register[`IRQ_EN_BIT]  = Seq_Busy;
      IRQ_Register[`IRQ_CLR_BIT] = (state == S_CLEAR);
   end

   // Full is judged on pre-pop occupancy, so a pop in the same cycle does not rescue the push.
   assign push      = (state == S_CLEAR);
   assign fifo_full = (level == LW'(FIFO_DEPTH));
   assign do_push   = push && !fifo_full;
   assign do_pop    = Sample_Ready && (level != '0);

   always_ff @(posedge SysClk) begin
      if (do_push)
         fifo_mem[wr_ptr] <= conv_hold;
   end

   always_ff @(posedge SysClk or negedge RST_n) begin
      if (!RST_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         Seq_Overflow <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(do_push) - LW'(do_pop);
         if (run_go)
            Seq_Overflow <= 1'b0;
         else if (push && fifo_full)
            Seq_Overflow <= 1'b1;
      end
   end

   assign Fifo_Level   = level;
   assign Sample_Valid = (level != '0);
   assign Sample_Data  = Sample_Valid ? fifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_imr_adc_7476a_sampler.sv
// Bench for imr_adc_7476a_sampler: behavioural ADC core model, expected-word queue and a pop-side monitor.

`ifndef CTRL_EN_BIT
`define CTRL_EN_BIT 0
`endif
`ifndef CTRL_START_BIT
`define CTRL_START_BIT 1
`endif
`ifndef CTRL_CLKDIV_LSB
`define CTRL_CLKDIV_LSB 8
`endif
`ifndef CTRL_CLKDIV_MSB
`define CTRL_CLKDIV_MSB 15
`endif
`ifndef IRQ_EN_BIT
`define IRQ_EN_BIT 0
`endif
`ifndef IRQ_CLR_BIT
`define IRQ_CLR_BIT 1
`endif
`ifndef STATUS_BUSY_BIT
`define STATUS_BUSY_BIT 0
`endif
`ifndef IMR_ADC_SAMPLER_SDW
`ifdef IMR_ADC_SAMPLER_TIMESTAMP_EN
`define IMR_ADC_SAMPLER_SDW 40
`else
`define IMR_ADC_SAMPLER_SDW 24
`endif
`endif

module tb_imr_adc_7476a_sampler;
   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 4096;
   localparam int CDW     = `CTRL_CLKDIV_MSB - `CTRL_CLKDIV_LSB + 1;
   localparam int SDW     = `IMR_ADC_SAMPLER_SDW;

   logic           SysClk, RST_n;
   logic           Cfg_Enable, Cfg_Start, Cfg_Stop;
   logic [CDW-1:0] Cfg_ClkDiv;
   logic [23:0]    Cfg_Period;
   logic [15:0]    Cfg_Count;
   logic [31:0]    Ctrl_Register, IRQ_Register, Status_Register;
   logic [31:0]    ADC_Data_A_Register, ADC_Data_B_Register;
   logic           IP_IRQ;
   logic [SDW-1:0] Sample_Data;
   logic           Sample_Valid, Sample_Ready;
   logic [4:0]     Fifo_Level;
   logic           Seq_Busy, Seq_Overflow, Seq_Overrun, Seq_Timeout;

   imr_adc_7476a_sampler #(.FIFO_DEPTH(DEPTH), .PERIOD_W(24), .TIMEOUT_CLKS(TIMEOUT)) dut (
      .SysClk(SysClk), .RST_n(RST_n),
      .Cfg_Enable(Cfg_Enable), .Cfg_Start(Cfg_Start), .Cfg_Stop(Cfg_Stop),
      .Cfg_ClkDiv(Cfg_ClkDiv), .Cfg_Period(Cfg_Period), .Cfg_Count(Cfg_Count),
      .Ctrl_Register(Ctrl_Register), .IRQ_Register(IRQ_Register),
      .Status_Register(Status_Register),
      .ADC_Data_A_Register(ADC_Data_A_Register), .ADC_Data_B_Register(ADC_Data_B_Register),
      .IP_IRQ(IP_IRQ),
      .Sample_Data(Sample_Data), .Sample_Valid(Sample_Valid), .Sample_Ready(Sample_Ready),
      .Fifo_Level(Fifo_Level), .Seq_Busy(Seq_Busy), .Seq_Overflow(Seq_Overflow),
      .Seq_Overrun(Seq_Overrun), .Seq_Timeout(Seq_Timeout)
   );

   initial SysClk = 1'b0;
   always #5 SysClk = ~SysClk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: every conversion the core delivers should reach the consumer in order,
   // unless DEPTH words are already waiting, in which case it is lost and overflow is flagged.
   logic [SDW-1:0] exp_q [$];
   logic [15:0]    ts_seen [$];
   bit             exp_ovf;
   int             words_rx;

   // ADC core model
   logic        core_busy, start_prev, no_irq, fixed_data;
   logic [11:0] a_val, b_val;
   logic [19:0] a_hi, b_hi;
   logic [15:0] ts_at_start;
   logic [31:0] cyc;
   logic [31:0] exp_ctrl;
   int          conv_left, quiet_left, n_conv, start_hi;
   logic        st;

   assign Status_Register     = 32'(core_busy) << `STATUS_BUSY_BIT;
   assign ADC_Data_A_Register = {a_hi, a_val};
   assign ADC_Data_B_Register = {b_hi, b_val};

   always @(posedge SysClk or negedge RST_n) begin
      if (!RST_n) cyc <= 32'd0;
      else        cyc <= cyc + 32'd1;
   end

   initial begin
      core_busy = 0; IP_IRQ = 0; start_prev = 0; a_val = 0; b_val = 0; a_hi = 0; b_hi = 0;
      conv_left = 0; quiet_left = 0; n_conv = 0; start_hi = 0; ts_at_start = 0;
      forever begin
         @(posedge SysClk or negedge RST_n);
         #1;
         if (!RST_n) begin
            core_busy = 0; IP_IRQ = 0; start_prev = 0; conv_left = 0; quiet_left = 0;
         end else begin
            st = Ctrl_Register[`CTRL_START_BIT];
            if (st) start_hi++;
            if (st && !start_prev) begin
               exp_ctrl = (32'd1 << `CTRL_EN_BIT) | (32'd1 << `CTRL_START_BIT) |
                          (32'(Cfg_ClkDiv) << `CTRL_CLKDIV_LSB);
               check("ctrl_at_start", Ctrl_Register, exp_ctrl);
               check("irq_reg_at_start", IRQ_Register, 32'd1 << `IRQ_EN_BIT);
               core_busy   = 1;
               ts_at_start = cyc[19:4];
               conv_left   = no_irq ? 0 : 2 * (int'(Cfg_ClkDiv) + 1) + 4;
            end
            if (!st && start_prev && no_irq) core_busy = 0;
            if (conv_left > 0) begin
               conv_left--;
               if (conv_left == 0) begin
                  a_val = fixed_data ? 12'h123 : 12'($urandom);
                  b_val = fixed_data ? 12'hABC : 12'($urandom);
                  a_hi  = 20'($urandom);
                  b_hi  = 20'($urandom);
                  IP_IRQ = 1;
                  n_conv++;
                  if (exp_q.size() < DEPTH) begin
`ifdef IMR_ADC_SAMPLER_TIMESTAMP_EN
                     exp_q.push_back({ts_at_start, b_val, a_val});
`else
                     exp_q.push_back({b_val, a_val});
`endif
                  end else begin
                     exp_ovf = 1;
                  end
               end
            end
            if (IRQ_Register[`IRQ_CLR_BIT] && IP_IRQ) begin
               IP_IRQ = 0;
               quiet_left = 4;
            end else if (quiet_left > 0) begin
               quiet_left--;
               if (quiet_left == 0) core_busy = 0;
            end
            start_prev = st;
         end
      end
   end

   // Consumer-side monitor
   logic [SDW-1:0] exp_w;
   always @(negedge SysClk) begin
      if (RST_n && Sample_Valid && Sample_Ready) begin
         words_rx++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got 0x%0h, none expected", Sample_Data);
         end else begin
            exp_w = exp_q.pop_front();
            check("sample_word", 64'(Sample_Data), 64'(exp_w));
`ifdef IMR_ADC_SAMPLER_TIMESTAMP_EN
            ts_seen.push_back(Sample_Data[39:24]);
`endif
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge SysClk);
      #1;
   endtask

   task automatic start_run(input int period, input int count, input int clkdiv);
      Cfg_Period = 24'(period);
      Cfg_Count  = 16'(count);
      Cfg_ClkDiv = CDW'(clkdiv);
      words_rx = 0;
      n_conv   = 0;
      exp_ovf  = 0;
      Cfg_Start = 1;
      step(1);
      Cfg_Start = 0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int i = 0;
      while (Seq_Busy && i < budget) begin
         @(negedge SysClk);
         i++;
      end
      check(name, Seq_Busy, 0);
      step(1);
   endtask

   task automatic drain(input int budget, input string name);
      int i = 0;
      while ((exp_q.size() != 0 || Sample_Valid) && i < budget) begin
         @(negedge SysClk);
         i++;
      end
      check(name, exp_q.size(), 0);
      step(1);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_ctrl"},     Ctrl_Register, 0);
      check({tag, "_irqreg"},   IRQ_Register, 0);
      check({tag, "_data"},     64'(Sample_Data), 0);
      check({tag, "_valid"},    Sample_Valid, 0);
      check({tag, "_level"},    Fifo_Level, 0);
      check({tag, "_busy"},     Seq_Busy, 0);
      check({tag, "_overflow"}, Seq_Overflow, 0);
      check({tag, "_overrun"},  Seq_Overrun, 0);
      check({tag, "_timeout"},  Seq_Timeout, 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int snap;
   int guard;

   initial begin
      RST_n = 0; Cfg_Enable = 0; Cfg_Start = 0; Cfg_Stop = 0; Cfg_ClkDiv = '0;
      Cfg_Period = '0; Cfg_Count = '0; Sample_Ready = 1; no_irq = 0; fixed_data = 0;
      exp_ovf = 0; words_rx = 0;
      #22;
      check_zero_outputs("reset");
      RST_n = 1;
      step(3);

      // Start without enable is ignored
      start_run(100, 1, 1);
      check("start_no_enable_busy", Seq_Busy, 0);
      Cfg_Enable = 1;
      step(2);

      // Nominal run, fixed data
      fixed_data = 1;
      start_run(2000, 4, 5);
      check("nominal_busy_after_start", Seq_Busy, 1);
      wait_idle(12000, "nominal_busy_falls");
      drain(200, "nominal_drain");
      check("nominal_words", words_rx, 4);
      check("nominal_overflow", Seq_Overflow, exp_ovf);
      check("nominal_overrun", Seq_Overrun, 0);
      check("nominal_timeout", Seq_Timeout, 0);
      fixed_data = 0;

      // Period shorter than a conversion
      start_run(10, 5, $urandom_range(2, 4));
      wait_idle(2000, "overrun_busy_falls");
      drain(200, "overrun_drain");
      check("overrun_flag", Seq_Overrun, 1);
      check("overrun_words", words_rx, 5);
      check("overrun_overflow", Seq_Overflow, exp_ovf);

      // Consumer stalled: FIFO fills and drops
      Sample_Ready = 0;
      start_run(40, 20, 1);
      wait_idle(3000, "fill_busy_falls");
      check("fill_level", Fifo_Level, DEPTH);
      check("fill_valid", Sample_Valid, 1);
      check("fill_overflow", Seq_Overflow, exp_ovf);
      check("fill_overflow_set", Seq_Overflow, 1);
      Sample_Ready = 1;
      drain(200, "fill_drain");
      check("fill_words", words_rx, DEPTH);
      check("fill_level_empty", Fifo_Level, 0);

      // Core never reports ready
      no_irq = 1;
      start_hi = 0;
      start_run(100, 1, 2);
      wait_idle(TIMEOUT + 500, "timeout_busy_falls");
      check("timeout_flag", Seq_Timeout, 1);
      check("timeout_start_low", Ctrl_Register[`CTRL_START_BIT], 0);
      check("timeout_window", (start_hi >= TIMEOUT && start_hi <= TIMEOUT + 2), 1);
      check("timeout_words", words_rx, 0);
      no_irq = 0;
      step(2);

      // Free-run, stop while a conversion is in flight
      start_run(50, 0, 3);
      check("stop_timeout_cleared", Seq_Timeout, 0);
      guard = 0;
      while (!(n_conv >= 3 && conv_left > 0) && guard < 2000) begin
         step(1);
         guard++;
      end
      check("stop_reached_conversion", conv_left > 0, 1);
      snap = n_conv;
      Cfg_Stop = 1;
      step(1);
      Cfg_Stop = 0;
      wait_idle(1000, "stop_busy_falls");
      drain(200, "stop_drain");
      check("stop_inflight_done", n_conv, snap + 1);
      check("stop_words", words_rx, n_conv);

`ifdef IMR_ADC_SAMPLER_TIMESTAMP_EN
      ts_seen.delete();
      start_run(1600, 3, 2);
      wait_idle(8000, "ts_busy_falls");
      drain(200, "ts_drain");
      check("ts_count", ts_seen.size(), 3);
      for (int i = 1; i < ts_seen.size(); i++)
         check("ts_delta", 16'(ts_seen[i] - ts_seen[i-1]), 16'd100);
`endif

      // Reset mid-run
      start_run(30, 0, 2);
      step(100);
      check("midrun_busy", Seq_Busy, 1);
      RST_n = 0;
      #2;
      exp_q.delete();
      check_zero_outputs("midrun_reset");
      step(3);
      RST_n = 1;
      step(5);
      check("post_reset_idle", Seq_Busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
